// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID / info register block.
package sysid_pkg;

   localparam int unsigned SYSID_DATA_W = 32;

   // Word offsets within the 8-word register window
   localparam logic [2:0] SYSID_OFF_ID      = 3'd0;
   localparam logic [2:0] SYSID_OFF_TS      = 3'd1;
   localparam logic [2:0] SYSID_OFF_VERSION = 3'd2;
   localparam logic [2:0] SYSID_OFF_CAPS    = 3'd3;
   localparam logic [2:0] SYSID_OFF_UPLO    = 3'd4;
   localparam logic [2:0] SYSID_OFF_UPHI    = 3'd5;
   localparam logic [2:0] SYSID_OFF_SCRATCH = 3'd6;
   localparam logic [2:0] SYSID_OFF_CTRL    = 3'd7;

   // CTRL register bit positions
   localparam int unsigned SYSID_CTRL_CLEAR  = 0;
   localparam int unsigned SYSID_CTRL_FREEZE = 1;

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with clear/freeze priority.
// Priority: reset > clear > freeze hold > increment; wraps silently.
module sysid_uptime_counter #(
   parameter int unsigned UPTIME_WIDTH = 64
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    freeze,
   output logic [UPTIME_WIDTH-1:0] count
);

   logic [UPTIME_WIDTH-1:0] count_q;
   logic [UPTIME_WIDTH-1:0] count_d;

   // Next-state: clear wins over freeze, freeze wins over increment
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (!freeze) begin
         count_d = count_q + UPTIME_WIDTH'(1);
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/sysid_info_regs.sv
// System-ID / build-info register slave with uptime counter, scratch and
// control registers. Reads are registered: readdatavalid one cycle after read.
module sysid_info_regs
   import sysid_pkg::*;
#(
   parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
   parameter logic [31:0] VERSION_VALUE   = 32'h0001_0000,
   parameter logic [31:0] CAPS_VALUE      = 32'h0000_0000,
   parameter int unsigned UPTIME_WIDTH    = 64,  // legal 33..64
   parameter int unsigned ADDR_WIDTH      = 3,   // minimum 3
   parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic                    read,
   input  logic                    write,
   input  logic [SYSID_DATA_W-1:0] writedata,
   input  logic [3:0]              byteenable,
   output logic [SYSID_DATA_W-1:0] readdata,
   output logic                    readdatavalid
);

   logic [UPTIME_WIDTH-1:0] count;
   logic [31:0]             hi_snap;
   logic [31:0]             scratch;
   logic                    freeze;
   logic                    clear_pend;
   logic [31:0]             rd_mux;
   logic [31:0]             rd_q;
   logic                    rdv_q;
   logic                    in_map;
   logic [2:0]              off;
   logic                    wr_ok;

   assign in_map = (address >> 3) == '0;
   assign off    = address[2:0];
   // A write coinciding with a read is dropped
   assign wr_ok  = write && !read && in_map;

   // CLEAR is registered, so the counter zeroes one edge after the write
   sysid_uptime_counter #(
      .UPTIME_WIDTH (UPTIME_WIDTH)
   ) u_uptime (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear_pend),
      .freeze  (freeze),
      .count   (count)
   );

   // Read data selection from the current (pre-edge) register values
   always_comb begin
      rd_mux = '0;
      if (in_map) begin
         case (off)
            SYSID_OFF_ID:      rd_mux = ID_VALUE;
            SYSID_OFF_TS:      rd_mux = TIMESTAMP_VALUE;
            SYSID_OFF_VERSION: rd_mux = VERSION_VALUE;
            SYSID_OFF_CAPS:    rd_mux = CAPS_VALUE;
            SYSID_OFF_UPLO:    rd_mux = count[31:0];
            SYSID_OFF_UPHI:    rd_mux = hi_snap;
            SYSID_OFF_SCRATCH: rd_mux = scratch;
            SYSID_OFF_CTRL:    rd_mux[SYSID_CTRL_FREEZE] = freeze;
            default:           rd_mux = '0;
         endcase
      end
   end

   // Read pipeline: data and valid registered one cycle after the strobe
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_q  <= '0;
         rdv_q <= 1'b0;
      end else begin
         rdv_q <= read;
         if (read) begin
            rd_q <= rd_mux;
         end
      end
   end

   // Upper uptime bits captured on a low-word read for a coherent 64-bit pair
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hi_snap <= '0;
      end else if (read && in_map && (off == SYSID_OFF_UPLO)) begin
         hi_snap <= 32'(count >> 32);
      end
   end

   // Byte-enabled scratch register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         scratch <= SCRATCH_RESET;
      end else if (wr_ok && (off == SYSID_OFF_SCRATCH)) begin
         for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) begin
               scratch[8*b +: 8] <= writedata[8*b +: 8];
            end
         end
      end
   end

   // Control: FREEZE is a stored bit, CLEAR a one-cycle pulse; lane 0 only
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         freeze     <= 1'b0;
         clear_pend <= 1'b0;
      end else begin
         clear_pend <= 1'b0;
         if (wr_ok && (off == SYSID_OFF_CTRL) && byteenable[0]) begin
            freeze     <= writedata[SYSID_CTRL_FREEZE];
            clear_pend <= writedata[SYSID_CTRL_CLEAR];
         end
      end
   end

   assign readdata      = rd_q;
   assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Bench for sysid_info_regs: directed scenarios plus random traffic, all
// compared against a transaction-level reference model.
module tb_sysid_info_regs;

   localparam logic [31:0] P_ID   = 32'h5511_ABF9;
   localparam logic [31:0] P_TS   = 32'h6543_2100;
   localparam logic [31:0] P_VER  = 32'h0002_0007;
   localparam logic [31:0] P_CAPS = 32'h0000_00F3;
   localparam logic [31:0] P_SCR  = 32'hA5A5_0F0F;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [3:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        readdatavalid;
   logic [31:0] readdata33;
   logic        readdatavalid33;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [63:0] m_up;
   logic [31:0] m_hi;
   logic [31:0] m_scr;
   logic        m_frz;
   logic        m_clr;
   logic        m_rdv;
   logic [31:0] m_rd;

   always #5 clock = ~clock;

   sysid_info_regs #(
      .ID_VALUE        (P_ID),
      .TIMESTAMP_VALUE (P_TS),
      .VERSION_VALUE   (P_VER),
      .CAPS_VALUE      (P_CAPS),
      .UPTIME_WIDTH    (64),
      .ADDR_WIDTH      (4),
      .SCRATCH_RESET   (P_SCR)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   // Narrow-counter instance used for the wrap scenario
   sysid_info_regs #(
      .ID_VALUE        (P_ID),
      .TIMESTAMP_VALUE (P_TS),
      .VERSION_VALUE   (P_VER),
      .CAPS_VALUE      (P_CAPS),
      .UPTIME_WIDTH    (33),
      .ADDR_WIDTH      (4),
      .SCRATCH_RESET   (P_SCR)
   ) dut33 (
      .clock         (clock),
      .reset_n       (reset_n),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata33),
      .readdatavalid (readdatavalid33)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [31:0] reg_value(input logic [3:0] a);
      case (a)
         4'd0:    return P_ID;
         4'd1:    return P_TS;
         4'd2:    return P_VER;
         4'd3:    return P_CAPS;
         4'd4:    return m_up[31:0];
         4'd5:    return m_hi;
         4'd6:    return m_scr;
         4'd7:    return {30'd0, m_frz, 1'b0};
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs presented to it
   task automatic model_step();
      logic [63:0] next_up;
      logic        wr;
      if (!reset_n) begin
         m_up = 0; m_hi = 0; m_scr = P_SCR; m_frz = 0; m_clr = 0; m_rdv = 0; m_rd = 0;
      end else begin
         wr    = write && !read && (address < 4'd8);
         m_rdv = read;
         if (read) m_rd = reg_value(address);
         if (read && address == 4'd4) m_hi = m_up[63:32];
         next_up = m_clr ? 64'd0 : (m_frz ? m_up : m_up + 64'd1);
         m_clr   = 1'b0;
         if (wr && address == 4'd6) begin
            for (int b = 0; b < 4; b++)
               if (byteenable[b]) m_scr[8*b +: 8] = writedata[8*b +: 8];
         end
         if (wr && address == 4'd7 && byteenable[0]) begin
            m_clr = writedata[0];
            m_frz = writedata[1];
         end
         m_up = next_up;
      end
   endtask

   // One bus cycle: drive at negedge, model at posedge, check just after it
   task automatic op(input bit rd, input bit wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
      read = rd; write = wr; address = a; writedata = wd; byteenable = be;
      @(posedge clock);
      model_step();
      #1;
      check_eq("rdv", {31'd0, readdatavalid}, {31'd0, m_rdv});
      check_eq("rdata", readdata, m_rd);
      @(negedge clock);
      read = 1'b0; write = 1'b0;
   endtask

   task automatic idle();
      op(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
   endtask

   logic [31:0] up_a;
   int          r;

   initial begin
      reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0;
      writedata = '0; byteenable = '0;
      @(negedge clock);
      idle();
      op(1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
      check_eq("reset_rdv", {31'd0, readdatavalid}, 32'd0);
      check_eq("reset_rdata", readdata, 32'd0);
      reset_n = 1'b1;

      // Wrap on the 33-bit counter: low word wraps, snapshot tracks bit 32
      force dut33.u_uptime.count_q = 33'h1_FFFF_FFFE;
      #1;
      release dut33.u_uptime.count_q;
      m_up = m_up;  // main instance unaffected
      idle();
      op(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
      check_eq("wrap_lo_pre", readdata33, 32'hFFFF_FFFF);
      op(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
      check_eq("wrap_lo", readdata33, 32'h0000_0000);
      op(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);
      check_eq("wrap_hi", readdata33, 32'h0000_0000);

      // Identity words back to back
      for (int i = 0; i < 4; i++) begin
         op(1'b1, 1'b0, 4'(i), 32'd0, 4'd0);
         check_eq("id_valid", {31'd0, readdatavalid}, 32'd1);
         case (i)
            0: check_eq("id", readdata, P_ID);
            1: check_eq("timestamp", readdata, P_TS);
            2: check_eq("version", readdata, P_VER);
            default: check_eq("caps", readdata, P_CAPS);
         endcase
      end
      idle();
      check_eq("rdv_drop", {31'd0, readdatavalid}, 32'd0);

      // Scratch lanes, RO write ignored, out-of-map offsets
      op(1'b0, 1'b1, 4'd6, 32'hDEAD_BEEF, 4'b1111);
      op(1'b0, 1'b1, 4'd6, 32'h0000_1200, 4'b0010);
      op(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);
      check_eq("scratch_lanes", readdata, 32'hDEAD_12EF);
      op(1'b0, 1'b1, 4'd0, 32'h1234_5678, 4'b1111);
      op(1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
      check_eq("id_ro", readdata, P_ID);
      op(1'b0, 1'b1, 4'd9, 32'hFFFF_FFFF, 4'b1111);
      op(1'b1, 1'b0, 4'd9, 32'd0, 4'd0);
      check_eq("unmapped", readdata, 32'd0);

      // Coherent uptime readout while frozen, then after release
      op(1'b0, 1'b1, 4'd7, 32'h2, 4'b0001);
      force dut.u_uptime.count_q = 64'h0000_0001_FFFF_FFFF;
      #1;
      release dut.u_uptime.count_q;
      m_up = 64'h0000_0001_FFFF_FFFF;
      op(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
      check_eq("coh_lo", readdata, 32'hFFFF_FFFF);
      op(1'b1, 1'b0, 4'd7, 32'd0, 4'd0);
      check_eq("ctrl_frozen", readdata, 32'h2);
      op(1'b0, 1'b1, 4'd7, 32'h0, 4'b0001);
      for (int i = 0; i < 10; i++) idle();
      op(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);
      check_eq("coh_hi", readdata, 32'h0000_0001);

      // Clear + freeze, then resume counting
      op(1'b0, 1'b1, 4'd7, 32'h3, 4'b0001);
      idle();
      idle();
      op(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
      check_eq("cleared", readdata, 32'd0);
      op(1'b1, 1'b0, 4'd7, 32'd0, 4'd0);
      check_eq("ctrl_rd", readdata, 32'h2);
      op(1'b0, 1'b1, 4'd7, 32'h0, 4'b0001);
      op(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
      up_a = readdata;
      for (int i = 0; i < 4; i++) idle();
      op(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
      check_eq("delta5", readdata - up_a, 32'd5);

      // Read and write together: read wins, write dropped
      op(1'b1, 1'b1, 4'd6, 32'h1111_1111, 4'b1111);
      check_eq("rw_read", readdata, 32'hDEAD_12EF);
      op(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);
      check_eq("rw_nowrite", readdata, 32'hDEAD_12EF);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         op(r < 4 || r == 7, r >= 4 && r <= 7, 4'($urandom_range(0, 9)),
            $urandom, 4'($urandom));
      end

      // Reset landing on a read edge
      reset_n = 1'b0;
      op(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);
      check_eq("rst_read_rdv", {31'd0, readdatavalid}, 32'd0);
      reset_n = 1'b1;
      op(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);
      check_eq("rst_scratch", readdata, P_SCR);
      op(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
      check_eq("rst_small_count", {31'd0, readdata < 32'd8}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
